// File: rtl/uart_core_cfg.sv
// uart_core_cfg: UART transceiver with runtime baud divisor, parity and stop-bit selection.
// TX and RX run independent dividers; RX decides each bit by majority-of-3 around the bit centre.
module uart_core_cfg #(
  parameter int WIDTH      = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic                 tx,
  input  logic [DIV_WIDTH-1:0] cfg_div,
  input  logic [1:0]           cfg_parity,
  input  logic                 cfg_stop2,
  input  logic [WIDTH-1:0]     tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [WIDTH-1:0]     rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_break,
  output logic                 rx_overrun,
  input  logic                 err_clear
);
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [OS_W-1:0]      OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]      OS_PEN   = OS_W'(OVERSAMPLE - 2);
  localparam logic [OS_W-1:0]      OS_ONE   = OS_W'(1);
  localparam logic [OS_W-1:0]      C_LO     = OS_W'(OVERSAMPLE / 2 - 2);
  localparam logic [OS_W-1:0]      C_MID    = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]      C_HI     = OS_W'(OVERSAMPLE / 2);
  localparam logic [CNT_W-1:0]     BIT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE  = CNT_W'(1);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(1);

  // state    | meaning
  // S_IDLE   | line idle, waiting for accept (TX) or start edge (RX)
  // S_START  | start bit
  // S_DATA   | data bits, LSB first
  // S_PARITY | optional parity bit
  // S_STOP1  | first stop bit
  // S_STOP2  | optional second stop bit
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2} state_t;

  logic [DIV_WIDTH-1:0] w_dm1;
  assign w_dm1 = (cfg_div == '0) ? '0 : cfg_div - DIV_ONE;

  // ---------------- transmitter ----------------
  state_t               r_tx_state, w_tx_nstate;
  logic [DIV_WIDTH-1:0] r_tx_div, r_tx_dm1;
  logic [OS_W-1:0]      r_tx_os;
  logic [CNT_W-1:0]     r_tx_cnt;
  logic [WIDTH-1:0]     r_tx_shift;
  logic                 r_tx_par_en, r_tx_par_bit, r_tx_stop2, r_tx;
  logic                 w_tx_accept, w_tx_tick, w_tx_bit_end, w_tx_pre_end, w_tx_nbit;

  assign tx           = r_tx;
  assign tx_ready     = (r_tx_state == S_IDLE) && !reset;
  assign w_tx_accept  = tx_valid && tx_ready;
  assign w_tx_tick    = (r_tx_state != S_IDLE) && (r_tx_div == '0);
  assign w_tx_bit_end = w_tx_tick && (r_tx_os == OS_LAST);
  // The last stop bit hands over one clock early: its final clock is the IDLE/accept cycle,
  // so a queued byte's start bit follows with the stop bit still exactly one bit long.
  assign w_tx_pre_end = (r_tx_dm1 == '0) ? (w_tx_tick && (r_tx_os == OS_PEN))
                                         : ((r_tx_os == OS_LAST) && (r_tx_div == DIV_ONE));

  always_comb begin
    w_tx_nstate = r_tx_state;
    w_tx_nbit   = r_tx;
    case (r_tx_state)
      S_IDLE: begin
        w_tx_nbit = 1'b1;
        if (w_tx_accept) begin
          w_tx_nstate = S_START;
          w_tx_nbit   = 1'b0;
        end
      end
      S_START: if (w_tx_bit_end) begin
        w_tx_nstate = S_DATA;
        w_tx_nbit   = r_tx_shift[0];
      end
      S_DATA: if (w_tx_bit_end) begin
        if (r_tx_cnt != BIT_LAST) begin
          w_tx_nbit = r_tx_shift[1];
        end else if (r_tx_par_en) begin
          w_tx_nstate = S_PARITY;
          w_tx_nbit   = r_tx_par_bit;
        end else begin
          w_tx_nstate = S_STOP1;
          w_tx_nbit   = 1'b1;
        end
      end
      S_PARITY: if (w_tx_bit_end) begin
        w_tx_nstate = S_STOP1;
        w_tx_nbit   = 1'b1;
      end
      S_STOP1: begin
        if (r_tx_stop2) begin
          if (w_tx_bit_end) w_tx_nstate = S_STOP2;
        end else if (w_tx_pre_end) begin
          w_tx_nstate = S_IDLE;
        end
      end
      S_STOP2: if (w_tx_pre_end) w_tx_nstate = S_IDLE;
      default: w_tx_nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_state   <= S_IDLE;
      r_tx         <= 1'b1;
      r_tx_div     <= '0;
      r_tx_dm1     <= '0;
      r_tx_os      <= '0;
      r_tx_cnt     <= '0;
      r_tx_shift   <= '0;
      r_tx_par_en  <= 1'b0;
      r_tx_par_bit <= 1'b0;
      r_tx_stop2   <= 1'b0;
    end else begin
      r_tx_state <= w_tx_nstate;
      r_tx       <= w_tx_nbit;
      if (w_tx_accept) begin
        r_tx_div     <= w_dm1;
        r_tx_dm1     <= w_dm1;
        r_tx_os      <= '0;
        r_tx_cnt     <= '0;
        r_tx_shift   <= tx_data;
        r_tx_par_en  <= (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
        r_tx_par_bit <= (^tx_data) ^ cfg_parity[1];
        r_tx_stop2   <= cfg_stop2;
      end else if (w_tx_tick) begin
        r_tx_div <= r_tx_dm1;
        r_tx_os  <= (r_tx_os == OS_LAST) ? '0 : r_tx_os + OS_ONE;
      end else if (r_tx_state != S_IDLE) begin
        r_tx_div <= r_tx_div - DIV_ONE;
      end
      if (w_tx_bit_end && (r_tx_state == S_DATA)) begin
        r_tx_cnt   <= r_tx_cnt + CNT_ONE;
        r_tx_shift <= r_tx_shift >> 1;
      end
    end
  end

  // ---------------- receiver ----------------
  state_t               r_rx_state, w_rx_nstate;
  logic                 r_rx_s1, r_rx_s2, r_rx_prev;
  logic [DIV_WIDTH-1:0] r_rx_div, r_rx_dm1;
  logic [OS_W-1:0]      r_rx_os;
  logic [CNT_W-1:0]     r_rx_cnt;
  logic [WIDTH-1:0]     r_rx_shift, r_rx_data;
  logic [1:0]           r_rx_samp;
  logic                 r_rx_par_en, r_rx_odd, r_rx_stop2, r_rx_pe, r_rx_fe;
  logic                 r_rx_valid, r_rx_perr, r_rx_ferr, r_rx_brk, r_rx_ovr;
  logic                 w_rx_start, w_rx_tick, w_rx_bit_end, w_rx_decide, w_rx_maj;
  logic                 w_rx_done, w_rx_fe_fin, w_rx_load, w_rx_ovr_set;

  assign w_rx_start   = (r_rx_state == S_IDLE) && r_rx_prev && !r_rx_s2;
  assign w_rx_tick    = (r_rx_state != S_IDLE) && (r_rx_div == '0);
  assign w_rx_bit_end = w_rx_tick && (r_rx_os == OS_LAST);
  assign w_rx_decide  = w_rx_tick && (r_rx_os == C_HI);
  assign w_rx_maj     = (r_rx_samp[0] & r_rx_samp[1]) | (r_rx_samp[0] & r_rx_s2) |
                        (r_rx_samp[1] & r_rx_s2);

  always_comb begin
    w_rx_nstate = r_rx_state;
    w_rx_done   = 1'b0;
    case (r_rx_state)
      S_IDLE:   if (w_rx_start) w_rx_nstate = S_START;
      S_START: begin
        if (w_rx_decide && w_rx_maj) w_rx_nstate = S_IDLE;
        else if (w_rx_bit_end)       w_rx_nstate = S_DATA;
      end
      S_DATA:   if (w_rx_bit_end && (r_rx_cnt == BIT_LAST))
                  w_rx_nstate = r_rx_par_en ? S_PARITY : S_STOP1;
      S_PARITY: if (w_rx_bit_end) w_rx_nstate = S_STOP1;
      S_STOP1: begin
        if (r_rx_stop2) begin
          if (w_rx_bit_end) w_rx_nstate = S_STOP2;
        end else if (w_rx_decide) begin
          w_rx_nstate = S_IDLE;
          w_rx_done   = 1'b1;
        end
      end
      S_STOP2: if (w_rx_decide) begin
        w_rx_nstate = S_IDLE;
        w_rx_done   = 1'b1;
      end
      default: w_rx_nstate = S_IDLE;
    endcase
  end

  assign w_rx_fe_fin  = r_rx_fe | !w_rx_maj;
  assign w_rx_load    = w_rx_done && (!r_rx_valid || rx_ready);
  assign w_rx_ovr_set = w_rx_done && r_rx_valid && !rx_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_state  <= S_IDLE;
      r_rx_s1     <= 1'b1;
      r_rx_s2     <= 1'b1;
      r_rx_prev   <= 1'b1;
      r_rx_div    <= '0;
      r_rx_dm1    <= '0;
      r_rx_os     <= '0;
      r_rx_cnt    <= '0;
      r_rx_shift  <= '0;
      r_rx_samp   <= '0;
      r_rx_par_en <= 1'b0;
      r_rx_odd    <= 1'b0;
      r_rx_stop2  <= 1'b0;
      r_rx_pe     <= 1'b0;
      r_rx_fe     <= 1'b0;
    end else begin
      r_rx_state <= w_rx_nstate;
      r_rx_s1    <= rx;
      r_rx_s2    <= r_rx_s1;
      r_rx_prev  <= r_rx_s2;
      if (w_rx_start) begin
        r_rx_div    <= w_dm1;
        r_rx_dm1    <= w_dm1;
        r_rx_os     <= '0;
        r_rx_cnt    <= '0;
        r_rx_pe     <= 1'b0;
        r_rx_fe     <= 1'b0;
        r_rx_par_en <= (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
        r_rx_odd    <= cfg_parity[1];
        r_rx_stop2  <= cfg_stop2;
      end else if (w_rx_tick) begin
        r_rx_div <= r_rx_dm1;
        r_rx_os  <= (r_rx_os == OS_LAST) ? '0 : r_rx_os + OS_ONE;
      end else if (r_rx_state != S_IDLE) begin
        r_rx_div <= r_rx_div - DIV_ONE;
      end
      if (w_rx_tick && (r_rx_os == C_LO))  r_rx_samp[0] <= r_rx_s2;
      if (w_rx_tick && (r_rx_os == C_MID)) r_rx_samp[1] <= r_rx_s2;
      if (w_rx_decide) begin
        case (r_rx_state)
          S_DATA:           r_rx_shift <= {w_rx_maj, r_rx_shift[WIDTH-1:1]};
          S_PARITY:         r_rx_pe    <= w_rx_maj ^ (^r_rx_shift) ^ r_rx_odd;
          S_STOP1, S_STOP2: if (!w_rx_maj) r_rx_fe <= 1'b1;
          default:          ;
        endcase
      end
      if (w_rx_bit_end && (r_rx_state == S_DATA)) r_rx_cnt <= r_rx_cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
      r_rx_perr  <= 1'b0;
      r_rx_ferr  <= 1'b0;
      r_rx_brk   <= 1'b0;
      r_rx_ovr   <= 1'b0;
    end else begin
      if (w_rx_load) begin
        r_rx_valid <= 1'b1;
        r_rx_data  <= r_rx_shift;
        r_rx_perr  <= r_rx_pe;
        r_rx_ferr  <= w_rx_fe_fin;
        r_rx_brk   <= (r_rx_shift == '0) && w_rx_fe_fin;
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
      if (w_rx_ovr_set)   r_rx_ovr <= 1'b1;
      else if (err_clear) r_rx_ovr <= 1'b0;
    end
  end

  assign rx_valid      = r_rx_valid;
  assign rx_data       = r_rx_data;
  assign rx_parity_err = r_rx_perr;
  assign rx_frame_err  = r_rx_ferr;
  assign rx_break      = r_rx_brk;
  assign rx_overrun    = r_rx_ovr;

endmodule

// File: tb/tb_uart_core_cfg.sv
// Directed bench for uart_core_cfg: TX bit timing table, loopback, RX error table and corner sequences.
module tb_uart_core_cfg;
  localparam int BIT = 64;  // 16 ticks x cfg_div 4

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_drv, loop_en, w_rx;
  logic        tx;
  logic [15:0] cfg_div;
  logic [1:0]  cfg_parity;
  logic        cfg_stop2;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready;
  logic        rx_parity_err, rx_frame_err, rx_break, rx_overrun, err_clear;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic        mon_en = 1'b0;
  logic [10:0] mon_q[$];

  assign w_rx = loop_en ? tx : rx_drv;

  uart_core_cfg dut (
    .clk(clk), .reset(reset), .rx(w_rx), .tx(tx),
    .cfg_div(cfg_div), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err),
    .rx_break(rx_break), .rx_overrun(rx_overrun), .err_clear(err_clear)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (mon_en && rx_valid && rx_ready)
      mon_q.push_back({rx_break, rx_frame_err, rx_parity_err, rx_data});

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx_drv = b;
    cycles(BIT);
  endtask

  task automatic send_rx(input logic [7:0] d, input logic [1:0] par, input logic st2,
                         input logic badp, input logic stopv);
    logic p;
    p = (^d) ^ (par == 2'b10) ^ badp;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (par == 2'b01 || par == 2'b10) drive_bit(p);
    drive_bit(stopv);
    if (st2) drive_bit(stopv);
    rx_drv = 1'b1;
  endtask

  typedef struct { int at; logic tx; logic rdy; } tx_vec_t;
  typedef struct { logic [7:0] d; logic p; } lb_vec_t;
  typedef struct {
    logic [7:0] d; logic [1:0] par; logic st2; logic badp; logic stopv;
    logic exp_pe; logic exp_fe; logic exp_brk;
  } rx_vec_t;

  tx_vec_t tv[15];
  lb_vec_t lv[3];
  rx_vec_t rv[4];

  initial begin
    int t, waited;
    int acc[3];
    logic ok, seen;
    logic [10:0] m;

    // 0xA5 8N1, cfg_div=4: offsets in clocks after the accept edge
    tv[0]  = '{0,   1'b0, 1'b0};
    tv[1]  = '{32,  1'b0, 1'b0};
    tv[2]  = '{63,  1'b0, 1'b0};
    tv[3]  = '{64,  1'b1, 1'b0};
    tv[4]  = '{96,  1'b1, 1'b0};
    tv[5]  = '{160, 1'b0, 1'b0};
    tv[6]  = '{224, 1'b1, 1'b0};
    tv[7]  = '{288, 1'b0, 1'b0};
    tv[8]  = '{352, 1'b0, 1'b0};
    tv[9]  = '{416, 1'b1, 1'b0};
    tv[10] = '{480, 1'b0, 1'b0};
    tv[11] = '{544, 1'b1, 1'b0};
    tv[12] = '{608, 1'b1, 1'b0};
    tv[13] = '{638, 1'b1, 1'b0};
    tv[14] = '{639, 1'b1, 1'b1};  // next ready cycle begins 640 clocks after the accept cycle

    lv[0] = '{8'h07, 1'b1};
    lv[1] = '{8'h00, 1'b0};
    lv[2] = '{8'hFF, 1'b0};

    rv[0] = '{8'h3C, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    rv[1] = '{8'h00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    rv[2] = '{8'h5A, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    rv[3] = '{8'h81, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    reset = 1'b1; rx_drv = 1'b1; loop_en = 1'b0;
    cfg_div = 16'd4; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    tx_data = 8'h00; tx_valid = 1'b0; rx_ready = 1'b0; err_clear = 1'b0;

    cycles(3);
    check("rst_tx", tx, 1);
    check("rst_tx_ready", tx_ready, 0);
    reset = 1'b0;
    cycles(1);
    check("post_rst_tx_ready", tx_ready, 1);
    check("post_rst_rx_valid", rx_valid, 0);
    check("post_rst_rx_data", rx_data, 0);
    check("post_rst_flags", {rx_parity_err, rx_frame_err, rx_break, rx_overrun}, 0);

    // TX timing table
    tx_data = 8'hA5; tx_valid = 1'b1;
    cycles(1);
    tx_valid = 1'b0;
    t = 0;
    for (int i = 0; i < 15; i++) begin
      cycles(tv[i].at - t);
      t = tv[i].at;
      check($sformatf("a5_tx@%0d", t), tx, tv[i].tx);
      check($sformatf("a5_ready@%0d", t), tx_ready, tv[i].rdy);
    end
    cycles(4);

    // Loopback, even parity, two stop bits, back-to-back
    loop_en = 1'b1; cfg_parity = 2'b01; cfg_stop2 = 1'b1; rx_ready = 1'b1; mon_en = 1'b1;
    cycles(4);
    tx_valid = 1'b1; tx_data = lv[0].d;
    for (int k = 0; k < 3; k++) begin
      waited = 0;
      while (!tx_ready && waited < 2000) begin cycles(1); waited++; end
      check("lb_ready_timeout", tx_ready, 1);
      cycles(1);
      acc[k] = cyc;
      if (k < 2) tx_data = lv[k+1].d;
      else tx_valid = 1'b0;
      if (k > 0) check($sformatf("lb_gap%0d", k), acc[k] - acc[k-1], 768);
      cycles(608);
      check($sformatf("lb_parity_bit%0d", k), tx, lv[k].p);
    end
    waited = 0;
    while (mon_q.size() < 3 && waited < 3000) begin cycles(1); waited++; end
    check("lb_rx_count", mon_q.size(), 3);
    for (int k = 0; k < 3; k++) begin
      if (mon_q.size() > 0) begin
        m = mon_q.pop_front();
        check($sformatf("lb_rx_data%0d", k), m[7:0], lv[k].d);
        check($sformatf("lb_rx_flags%0d", k), m[10:8], 0);
      end
    end
    check("lb_overrun", rx_overrun, 0);
    mon_en = 1'b0; loop_en = 1'b0; rx_ready = 1'b0;
    cycles(BIT);

    // RX error table, bench-driven line
    for (int i = 0; i < 4; i++) begin
      cfg_parity = rv[i].par; cfg_stop2 = rv[i].st2;
      send_rx(rv[i].d, rv[i].par, rv[i].st2, rv[i].badp, rv[i].stopv);
      cycles(32);
      check($sformatf("rx%0d_valid", i), rx_valid, 1);
      check($sformatf("rx%0d_data", i), rx_data, rv[i].d);
      check($sformatf("rx%0d_parity_err", i), rx_parity_err, rv[i].exp_pe);
      check($sformatf("rx%0d_frame_err", i), rx_frame_err, rv[i].exp_fe);
      check($sformatf("rx%0d_break", i), rx_break, rv[i].exp_brk);
      check($sformatf("rx%0d_overrun", i), rx_overrun, 0);
      rx_ready = 1'b1;
      cycles(1);
      rx_ready = 1'b0;
      check($sformatf("rx%0d_valid_clr", i), rx_valid, 0);
      cycles(16);
    end

    // Short low glitch is a false start
    cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    rx_drv = 1'b0;
    cycles(20);
    rx_drv = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 800; i++) begin
      cycles(1);
      if (rx_valid) seen = 1'b1;
    end
    check("glitch_no_valid", seen, 0);

    // Overrun: second frame dropped while first is held
    send_rx(8'h11, 2'b00, 1'b0, 1'b0, 1'b1);
    cycles(16);
    check("ovr_first_valid", rx_valid, 1);
    check("ovr_not_yet", rx_overrun, 0);
    send_rx(8'h22, 2'b00, 1'b0, 1'b0, 1'b1);
    cycles(16);
    check("ovr_valid_held", rx_valid, 1);
    check("ovr_data_held", rx_data, 8'h11);
    check("ovr_set", rx_overrun, 1);
    err_clear = 1'b1;
    cycles(1);
    err_clear = 1'b0;
    check("ovr_cleared", rx_overrun, 0);
    check("ovr_valid_after_clear", rx_valid, 1);
    check("ovr_data_after_clear", rx_data, 8'h11);

    // Reset in the middle of TX and RX data bits
    tx_data = 8'h00; tx_valid = 1'b1;
    cycles(1);
    tx_valid = 1'b0;
    rx_drv = 1'b0;
    cycles(3 * BIT);
    check("mid_tx_low", tx, 0);
    reset = 1'b1;
    cycles(1);
    check("midrst_tx", tx, 1);
    check("midrst_tx_ready", tx_ready, 0);
    check("midrst_rx_valid", rx_valid, 0);
    check("midrst_rx_data", rx_data, 0);
    check("midrst_flags", {rx_parity_err, rx_frame_err, rx_break, rx_overrun}, 0);
    rx_drv = 1'b1;
    reset = 1'b0;
    cycles(1);
    check("after_rst_tx_ready", tx_ready, 1);
    check("after_rst_tx", tx, 1);
    check("after_rst_rx_valid", rx_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/uart_core_cfg.md
Name: uart_core_cfg

Overview:
Next-generation UART transceiver with runtime-programmable baud divisor, parity (none/even/odd) and stop-bit count, and per-byte error reporting. TX and RX each have their own divider, so bit timing is exact from the start edge. RX uses a 2-flop synchroniser, majority-of-3 centre sampling and false-start rejection. Host side is valid/ready on both directions; it sits between a CPU-side FIFO or register bank and the board pins.

Parameters:
WIDTH, 8, data bits per frame, legal 5..9.
OVERSAMPLE, 16, baud ticks per bit, even, minimum 8.
DIV_WIDTH, 16, width of cfg_div.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
rx  input  1  asynchronous serial input
tx  output  1  serial output, idle high
cfg_div  input  DIV_WIDTH  clocks per baud tick; 0 is treated as 1
cfg_parity  input  2  00 none, 01 even, 10 odd, 11 none
cfg_stop2  input  1  0 = one stop bit, 1 = two stop bits
tx_data  input  WIDTH  byte to send
tx_valid  input  1  host offers tx_data
tx_ready  output  1  core accepts tx_data this cycle
rx_data  output  WIDTH  received byte
rx_valid  output  1  rx_data and error flags valid
rx_ready  input  1  host consumes rx_data
rx_parity_err  output  1  parity mismatch for the held byte
rx_frame_err  output  1  stop bit sampled low for the held byte
rx_break  output  1  held byte is all zeros with a frame error
rx_overrun  output  1  sticky: a frame was dropped
err_clear  input  1  clears rx_overrun

Behaviour:
- Let D = max(cfg_div, 1). Bit period = OVERSAMPLE*D clocks.
- Config is latched at frame start (TX accept / RX start edge). Changes mid-frame do not affect the current frame.
- Reset: tx=1, tx_ready=0 during reset and 1 the first cycle after. rx_valid=0, all error flags 0, rx_data=0, both FSMs IDLE. Reset mid-frame aborts immediately; tx is high on the next cycle.
- TX divider: cleared on accept, emits a 1-cycle tick every D clocks.
- TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP1 -> [STOP2] -> IDLE.
  - tx_ready=1 only in IDLE. Accept when tx_valid && tx_ready; tx_data is latched.
  - tx is registered and goes low the cycle after accept. Each bit lasts exactly OVERSAMPLE*D clocks.
  - Data is sent LSB first. The parity bit is the XOR of the data bits (even) or its inverse (odd).
  - After the last stop bit completes, the FSM is back in IDLE with tx_ready=1. Total accept-to-ready = (1+WIDTH+P+S)*OVERSAMPLE*D clocks, where P = 0/1 parity bits and S = 1/2 stop bits.
  - If tx_valid is held, the next start bit follows with no idle gap.
- RX input: 2-flop synchroniser, plus a previous-value register for edge detection.
- RX divider: cleared on start detection; ticks every D clocks. A tick counter 0..OVERSAMPLE-1 runs within each bit.
- RX majority sampling: each bit is decided by majority of samples at ticks C-1, C and C+1, where C = OVERSAMPLE/2-1.
- RX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP1 -> [STOP2] -> IDLE.
  - IDLE: a synced 1->0 transition starts a frame.
  - START: if the majority is 1, it is a false start; return to IDLE with no output.
  - DATA: shift bits LSB first.
  - PARITY: compare against the computed parity; mismatch sets the pending parity error.
  - STOP: a majority of 0 on any stop bit sets the pending frame error.
- RX completion: the frame completes at tick C+1 of the last stop bit and the FSM returns to IDLE, so it can resync to the next start edge.
- Delivery at completion:
  - If rx_valid=0, or rx_valid && rx_ready in the same cycle: load rx_data, rx_parity_err, rx_frame_err and rx_break, and set rx_valid=1 on the next cycle.
  - If rx_valid && !rx_ready: drop the new frame, keep the held byte and flags unchanged, set rx_overrun.
- rx_valid clears the cycle after rx_valid && rx_ready with no new completion.
- rx_overrun clears only on err_clear or reset. If err_clear and a new overrun occur in the same cycle, the set wins.
- Parity bits: none when cfg_parity is 00 or 11, which skips the PARITY state.

Test Plan:
- cfg_div=4, 8N1, send 0xA5 -> tx low one cycle after accept; bit values 0,1,0,1,0,0,1,0,1,1, each 64 clocks; tx_ready again 640 clocks after accept.
- Loopback tx->rx, even parity, 2 stop bits, bytes 0x07, 0x00, 0xFF back-to-back -> parity bits 1,0,0; rx_data matches each byte; all error flags 0; tx_ready gaps 768 clocks.
- Odd parity with a wrong parity bit driven by the bench on byte 0x3C -> rx_valid with rx_data=0x3C, rx_parity_err=1, rx_frame_err=0.
- Drive rx low for a full 8N1 frame time (0x00, stop=0) -> rx_frame_err=1, rx_break=1. Then a 20-clock low glitch (cfg_div=4, under half a bit) -> no rx_valid.
- Two frames received with rx_ready=0 -> first byte held, second dropped, rx_overrun=1. err_clear pulse -> rx_overrun=0 while rx_valid stays 1.
- Assert reset at mid-DATA of a TX frame and mid-DATA of an RX frame -> tx=1 next cycle, rx_valid=0, flags 0, tx_ready=1 the cycle after reset deasserts.
